// File: rtl/apb_master_bridge_if.sv
// Request/response and APB3 signal bundle for apb_master_bridge.
// master: bridge view; slave: requester + APB peripheral view.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata,
    input  rsp_ready, prdata, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata,
    output rsp_ready, prdata, pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// valid/ready request -> APB3 SETUP/ACCESS bridge, one transfer in flight.
// Ports: pclk, presetn (async low), bus (req/rsp + APB master signals).
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic presetn,
  apb_master_bridge_if.master bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TLAST = CW'(TL);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              pen_q, pen_d;
  logic              rv_q, rv_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      pwrite_q <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      pwrite_q <= pwrite_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    pwrite_d = pwrite_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    rv_d     = rv_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_write;
          pwdata_d = bus.req_wdata;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          err_d    = 1'b0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready wins over an expiring timeout on the same edge
        if (bus.pready) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rdata_d = pwrite_q ? '0 : bus.prdata;
          err_d   = 1'b0;
          rv_d    = 1'b1;
          state_d = RESP;
        end else if (TIMEOUT != 0) begin
          if (cnt_q == TLAST) begin
            psel_d  = 1'b0;
            pen_d   = 1'b0;
            rdata_d = '0;
            err_d   = 1'b1;
            rv_d    = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = pen_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small APB RAM slave
// whose wait states are set per transfer.
module tb_apb_master_bridge;

  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)
  ) dut (
    .pclk(pclk),
    .presetn(presetn),
    .bus(bus)
  );

  logic [31:0] mem [16];
  int wait_n;
  int acc_cnt;

  assign bus.pready = bus.psel && bus.penable
                    && (acc_cnt == wait_n);
  assign bus.prdata = mem[bus.paddr[3:0]];

  always @(posedge pclk) begin
    if (bus.psel && bus.penable) begin
      if (bus.pready) begin
        acc_cnt <= 0;
        if (bus.pwrite) mem[bus.paddr[3:0]] <= bus.pwdata;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          waits;
    logic [31:0] er;
    logic        ee;
    int          eacc;
  } vec_t;

  vec_t v[8];

  task automatic xfer(input int id, input vec_t t);
    int acc;
    int n;
    logic stab;
    logic [31:0] a0;
    logic [31:0] d0;
    logic w0;
    @(negedge pclk);
    wait_n        = t.waits;
    bus.req_valid = 1'b1;
    bus.req_write = t.w;
    bus.req_addr  = t.a;
    bus.req_wdata = t.d;
    bus.rsp_ready = 1'b1;
    chk($sformatf("v%0d_req_ready", id), 32'(bus.req_ready), 32'd1);
    @(negedge pclk);
    bus.req_valid = 1'b0;
    chk($sformatf("v%0d_setup", id),
        32'({bus.psel, bus.penable}), 32'b10);
    a0 = bus.paddr;
    w0 = bus.pwrite;
    d0 = bus.pwdata;
    stab = (a0 == t.a) && (w0 == t.w) && (d0 == t.d);
    acc = 0;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge pclk);
      n++;
      if (bus.psel && bus.penable) begin
        acc++;
        if (bus.paddr != a0 || bus.pwrite != w0 || bus.pwdata != d0)
          stab = 1'b0;
      end
    end
    chk($sformatf("v%0d_rsp_seen", id), 32'(bus.rsp_valid), 32'd1);
    chk($sformatf("v%0d_rdata", id), bus.rsp_rdata, t.er);
    chk($sformatf("v%0d_err", id), 32'(bus.rsp_err), 32'(t.ee));
    chk($sformatf("v%0d_access_cycles", id), 32'(acc), 32'(t.eacc));
    chk($sformatf("v%0d_stable", id), 32'(stab), 32'd1);
    chk($sformatf("v%0d_apb_off", id),
        32'({bus.psel, bus.penable}), 32'd0);
    @(negedge pclk);
    chk($sformatf("v%0d_idle", id),
        32'({bus.rsp_valid, bus.req_ready}), 32'b01);
  endtask

  initial begin
    v[0] = '{1'b1, 32'd5, 32'hDEADBEEF, 0,    32'h0,        1'b0, 1};
    v[1] = '{1'b0, 32'd5, 32'h0,        0,    32'hDEADBEEF, 1'b0, 1};
    v[2] = '{1'b1, 32'd9, 32'h12345678, 2,    32'h0,        1'b0, 3};
    v[3] = '{1'b0, 32'd9, 32'h11112222, 3,    32'h12345678, 1'b0, 4};
    v[4] = '{1'b0, 32'd5, 32'h0,        1000, 32'h0,        1'b1, 16};
    v[5] = '{1'b0, 32'd5, 32'h0,        15,   32'hDEADBEEF, 1'b0, 16};
    v[6] = '{1'b1, 32'd5, 32'hBAD0BAD0, 1000, 32'h0,        1'b1, 16};
    v[7] = '{1'b0, 32'd5, 32'h0,        0,    32'hDEADBEEF, 1'b0, 1};

    presetn       = 1'b0;
    wait_n        = 0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_ctrl", 32'({bus.psel, bus.penable, bus.rsp_valid,
                         bus.rsp_err, bus.pwrite}), 32'd0);
    chk("rst_paddr", bus.paddr, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    presetn = 1'b1;

    for (int i = 0; i < 8; i++) xfer(i, v[i]);

    // response backpressure with a new request waiting
    begin
      int n;
      @(negedge pclk);
      wait_n        = 0;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'd9;
      bus.rsp_ready = 1'b0;
      @(negedge pclk);
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(negedge pclk);
        n++;
      end
      chk("bp_rsp_seen", 32'(bus.rsp_valid), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'd5;
      for (int k = 0; k < 5; k++) begin
        @(negedge pclk);
        chk($sformatf("bp_hold%0d", k),
            32'({bus.rsp_valid, bus.req_ready, bus.psel}), 32'b100);
        chk($sformatf("bp_rdata%0d", k), bus.rsp_rdata, 32'h12345678);
      end
      bus.rsp_ready = 1'b1;
      @(negedge pclk);
      chk("bp_release", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
      @(negedge pclk);
      bus.req_valid = 1'b0;
      chk("bp_next_setup", 32'({bus.psel, bus.penable}), 32'b10);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(negedge pclk);
        n++;
      end
      chk("bp_next_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      @(negedge pclk);
    end

    // asynchronous reset in the middle of ACCESS
    @(negedge pclk);
    wait_n        = 1000;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'd5;
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.req_valid = 1'b0;
    @(negedge pclk);
    chk("ar_in_access", 32'({bus.psel, bus.penable}), 32'b11);
    #2 presetn = 1'b0;
    #1;
    chk("ar_async", 32'({bus.psel, bus.penable, bus.rsp_valid}), 32'd0);
    chk("ar_paddr", bus.paddr, 32'd0);
    @(negedge pclk);
    chk("ar_no_rsp", 32'(bus.rsp_valid), 32'd0);
    presetn = 1'b1;
    xfer(8, '{1'b1, 32'd7, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 1});
    xfer(9, '{1'b0, 32'd7, 32'h0, 1, 32'hA5A5A5A5, 1'b0, 2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready request/response interface into APB3 SETUP/ACCESS transfers.
- Sits directly upstream of the APB peripheral subsystem, e.g. the APB RAM slave, and drives its paddr/psel/penable/pwrite/pwdata.
- Handles one outstanding transfer at a time, supports slave wait states via pready, and bounds waits with a timeout that returns an error response.

Parameters:
- ADDR_W, 32, width of req_addr and paddr.
- DATA_W, 32, width of wdata/rdata buses.
- TIMEOUT, 16, maximum ACCESS cycles to wait for pready; 0 disables the timeout.

Ports:
- pclk  input  1  APB clock; all state updates on rising edge.
- presetn  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  bridge can accept a request.
- req_addr  input  ADDR_W  transfer address.
- req_write  input  1  1 = write, 0 = read.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumer ready.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  1 = timeout error.
- paddr  output  ADDR_W  APB address.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- pwdata  output  DATA_W  APB write data.
- prdata  input  DATA_W  APB read data.
- pready  input  1  APB slave ready.

Behaviour:
- Reset (asynchronous, presetn low): state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0; timeout counter = 0. Takes effect immediately, including mid-transfer; no response is produced for an aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- req_ready = (state==IDLE), combinational. Deasserted in all other states.
- IDLE: on an edge with req_valid && req_ready:
  - register req_addr->paddr, req_write->pwrite, req_wdata->pwdata (pwdata is registered for reads too);
  - psel=1, penable=0, go to SETUP.
- SETUP: lasts exactly one cycle. Next edge: penable=1, counter=0, go to ACCESS.
- ACCESS: each edge samples pready.
  - pready=1: psel=0, penable=0; rsp_rdata = pwrite ? 0 : prdata; rsp_err=0; rsp_valid=1; go to RESP.
  - pready=0 with TIMEOUT≠0: counter increments. On the edge where the counter would reach TIMEOUT (the TIMEOUT-th ACCESS cycle without pready): psel=0, penable=0, rsp_rdata=0, rsp_err=1, rsp_valid=1, go to RESP.
  - pready=1 on that same edge: the success path wins.
  - Counter width is $clog2(TIMEOUT+1); it never wraps.
- paddr, pwrite, pwdata remain stable from SETUP through the end of ACCESS. After the transfer they hold their last value.
- RESP: rsp_valid, rsp_rdata, rsp_err held stable until an edge with rsp_ready=1. On that edge: rsp_valid=0, go to IDLE. rsp_err is cleared on the next accepted request.
- Timing with zero-wait slave and rsp_ready=1: request accepted at edge N, psel high from N, penable high from N+1, response registered at N+2, consumed at N+3, req_ready high again after N+3. Minimum 4 cycles per transfer.
- No APB transfer starts while a response is pending; backpressure propagates to req_ready.
- psel, penable, rsp_valid are never asserted together with req_ready.

Test Plan:
- Write 0xDEADBEEF to addr 5 into apb_ram (zero wait) -> psel=1/penable=0 for 1 cycle, then psel=penable=pwrite=1 with paddr=5 for 1 cycle; rsp_valid with rsp_err=0, rsp_rdata=0.
- Read addr 5 afterwards -> pwrite=0 during transfer; rsp_rdata=0xDEADBEEF, rsp_err=0.
- Slave model holds pready=0 for 3 ACCESS cycles, read data 0x12345678 -> penable high for 4 cycles; paddr/pwrite/pwdata stable throughout; rsp_rdata=0x12345678.
- pready stuck 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then psel=penable=0, rsp_err=1, rsp_rdata=0. Repeat with pready=1 on the 16th cycle -> rsp_err=0.
- rsp_ready held 0 for 5 cycles after a response with req_valid=1 -> rsp_valid/rsp_rdata stable, req_ready=0, psel stays 0; next transfer starts only after rsp_ready handshake.
- Assert presetn low during ACCESS -> psel, penable, rsp_valid go 0 immediately (asynchronous); after release, a write/read of 0xA5A5A5A5 to addr 7 completes correctly.
